// File: rtl/maq_bcd.sv
// Two-digit BCD modulo counter with up/down count, checked load and
// a combinational wrap strobe for cascading sec/min/hour stages.
module maq_bcd #(
    parameter int MODULUS   = 60,
    parameter int MSD_WIDTH = 3
) (
    input  logic                 maqb_clock,
    input  logic                 maqb_reset,
    input  logic                 maqb_enable,
    input  logic                 maqb_up,
    input  logic                 maqb_load,
    input  logic [3:0]           maqb_ld_Lsd,
    input  logic [MSD_WIDTH-1:0] maqb_ld_Msd,
    output logic [3:0]           maqb_Lsd,
    output logic [MSD_WIDTH-1:0] maqb_Msd,
    output logic                 maqb_carry,
    output logic                 maqb_load_err
);

    localparam int TC_MSD = (MODULUS - 1) / 10;
    localparam int TC_LSD = (MODULUS - 1) % 10;
    localparam int VW     = MSD_WIDTH + 7;

    localparam logic [VW-1:0]        TOP   = VW'(MODULUS - 1);
    localparam logic [VW-1:0]        LIMIT = VW'(MODULUS);
    localparam logic [MSD_WIDTH-1:0] TC_M  = MSD_WIDTH'(TC_MSD);
    localparam logic [3:0]           TC_L  = 4'(TC_LSD);
    localparam logic [MSD_WIDTH-1:0] M_ONE = MSD_WIDTH'(1);

    if (MODULUS < 2 || MODULUS > 100) begin : g_bad_modulus
        $error("maq_bcd: MODULUS must be within 2..100");
    end
    if (TC_MSD > (1 << MSD_WIDTH) - 1) begin : g_bad_width
        $error("maq_bcd: MSD_WIDTH too narrow for MODULUS");
    end

    logic [3:0]           lsd_q, lsd_d;
    logic [MSD_WIDTH-1:0] msd_q, msd_d;
    logic                 err_q, err_d;

    logic [VW-1:0] value;
    logic [VW-1:0] ld_value;
    logic          at_top;
    logic          at_zero;
    logic          over;
    logic          ld_ok;
    logic          wrap;

    always_comb begin
        value    = VW'(msd_q) * VW'(10) + VW'(lsd_q);
        ld_value = VW'(maqb_ld_Msd) * VW'(10) + VW'(maqb_ld_Lsd);
        at_top   = (value == TOP);
        at_zero  = (value == '0);
        // Unreachable states are folded into the up-count wrap.
        over     = (lsd_q > 4'd9) || (value > TOP);
        ld_ok    = (maqb_ld_Lsd <= 4'd9) && (ld_value < LIMIT);
        wrap     = maqb_up ? (at_top || over) : at_zero;
    end

    assign maqb_carry = maqb_enable && !maqb_load && wrap;

    always_comb begin
        lsd_d = lsd_q;
        msd_d = msd_q;
        err_d = 1'b0;
        if (maqb_load) begin
            if (ld_ok) begin
                lsd_d = maqb_ld_Lsd;
                msd_d = maqb_ld_Msd;
            end else begin
                err_d = 1'b1;
            end
        end else if (maqb_enable) begin
            if (maqb_up) begin
                if (at_top || over) begin
                    lsd_d = '0;
                    msd_d = '0;
                end else if (lsd_q == 4'd9) begin
                    lsd_d = '0;
                    msd_d = msd_q + M_ONE;
                end else begin
                    lsd_d = lsd_q + 4'd1;
                end
            end else begin
                if (at_zero || over) begin
                    lsd_d = TC_L;
                    msd_d = TC_M;
                end else if (lsd_q == 4'd0) begin
                    lsd_d = 4'd9;
                    msd_d = msd_q - M_ONE;
                end else begin
                    lsd_d = lsd_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge maqb_clock or negedge maqb_reset) begin
        if (!maqb_reset) begin
            lsd_q <= '0;
            msd_q <= '0;
            err_q <= 1'b0;
        end else begin
            lsd_q <= lsd_d;
            msd_q <= msd_d;
            err_q <= err_d;
        end
    end

    assign maqb_Lsd      = lsd_q;
    assign maqb_Msd      = msd_q;
    assign maqb_load_err = err_q;

endmodule

// File: tb/tb_maq_bcd.sv
// Scoreboard bench for maq_bcd (MODULUS=60): directed cases, random
// traffic against an integer reference model, async reset checks.
module tb_maq_bcd;

    localparam int MOD = 60;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [3:0] ld_lsd = '0;
    logic [2:0] ld_msd = '0;
    logic [3:0] lsd;
    logic [2:0] msd;
    logic       carry;
    logic       lerr;

    typedef struct {
        bit carry;
        int lsd;
        int msd;
        bit err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   mv = 0;
    bit   merr = 1'b0;

    maq_bcd #(.MODULUS(MOD), .MSD_WIDTH(3)) dut (
        .maqb_clock   (clk),
        .maqb_reset   (rst_n),
        .maqb_enable  (enable),
        .maqb_up      (up),
        .maqb_load    (load),
        .maqb_ld_Lsd  (ld_lsd),
        .maqb_ld_Msd  (ld_msd),
        .maqb_Lsd     (lsd),
        .maqb_Msd     (msd),
        .maqb_carry   (carry),
        .maqb_load_err(lerr)
    );

    always #5 clk = ~clk;

    task automatic check(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, got, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and push what the counter must do.
    task automatic step(bit ld, int ll, int lm, bit en, bit u);
        exp_t e;
        @(posedge clk);
        #2;
        load   = ld;
        ld_lsd = 4'(ll);
        ld_msd = 3'(lm);
        enable = en;
        up     = u;
        e.carry = en && !ld &&
                  ((u && mv == MOD - 1) || (!u && mv == 0));
        if (ld) begin
            if (ll <= 9 && 10 * lm + ll < MOD) begin
                mv   = 10 * lm + ll;
                merr = 1'b0;
            end else begin
                merr = 1'b1;
            end
        end else begin
            merr = 1'b0;
            if (en) mv = u ? (mv + 1) % MOD : (mv + MOD - 1) % MOD;
        end
        e.lsd = mv % 10;
        e.msd = mv / 10;
        e.err = merr;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) check("carry", int'(carry), int'(sb[0].carry));
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("lsd", int'(lsd), e.lsd);
                check("msd", int'(msd), e.msd);
                check("load_err", int'(lerr), int'(e.err));
            end
        end
    end

    initial begin
        #3;
        check("reset_lsd", int'(lsd), 0);
        check("reset_msd", int'(msd), 0);
        check("reset_err", int'(lerr), 0);
        check("reset_carry", int'(carry), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        repeat (61) step(0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 4, 0, 0);
        step(0, 0, 0, 1, 0);
        step(1, 3, 7, 1, 1);
        step(0, 0, 0, 0, 1);
        step(1, 10, 0, 0, 1);
        step(1, 9, 5, 0, 0);
        step(1, 2, 1, 1, 1);
        step(1, 9, 5, 0, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 7) == 0,
                 int'($urandom_range(0, 11)),
                 int'($urandom_range(0, 6)),
                 $urandom_range(0, 3) != 0,
                 1'($urandom));
        end

        for (int i = 0; i < 10; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #2;
        end
        if (sb.size() != 0) check("drain", sb.size(), 0);
        load   = 1'b0;
        enable = 1'b0;

        // Reset while counting at 37 with a load error pending.
        load   = 1'b1;
        ld_lsd = 4'd7;
        ld_msd = 3'd3;
        @(posedge clk);
        #2;
        check("ld37_lsd", int'(lsd), 7);
        check("ld37_msd", int'(msd), 3);
        ld_lsd = 4'd10;
        @(posedge clk);
        #2;
        check("bad_ld_err", int'(lerr), 1);
        check("bad_ld_lsd", int'(lsd), 7);
        load   = 1'b0;
        enable = 1'b1;
        up     = 1'b1;
        #1;
        check("carry_37", int'(carry), 0);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_lsd", int'(lsd), 0);
        check("async_msd", int'(msd), 0);
        check("async_err", int'(lerr), 0);
        check("async_carry", int'(carry), 0);
        @(posedge clk);
        #1;
        check("held_lsd", int'(lsd), 0);
        check("held_carry", int'(carry), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
